// File: rtl/scoreboard_ctrl_pkg.sv
// Shared definitions for the register scoreboard / issue controller.
// REG_ADDR_SIZE sets the register address width (address width = REG_ADDR_SIZE+1).
`ifndef REG_ADDR_SIZE
`define REG_ADDR_SIZE 4
`endif

package scoreboard_ctrl_pkg;

    localparam int SB_ADDR_W = `REG_ADDR_SIZE + 1;

    typedef enum logic {
        SB_RUN   = 1'b0,
        SB_DRAIN = 1'b1
    } sb_state_t;

endpackage

// File: rtl/scoreboard_ctrl_sb_counter.sv
// sb_counter: W-bit up/down counter with one increment and two decrement
// strobes. The net delta is applied each cycle; a result below zero is held
// at zero and flagged on underflow for that cycle; a result above the
// maximum is held at the maximum.
module sb_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec_a,
    input  logic         dec_b,
    output logic [W-1:0] count,
    output logic         underflow
);

    logic signed [W+1:0] sum;
    logic [W-1:0]        count_nxt;

    function automatic logic [W-1:0] clamp_cnt(input logic signed [W+1:0] v);
        logic signed [W+1:0] max_v;
        max_v = $signed({2'b00, {W{1'b1}}});
        if (v < 0)
            clamp_cnt = '0;
        else if (v > max_v)
            clamp_cnt = {W{1'b1}};
        else
            clamp_cnt = v[W-1:0];
    endfunction

    // Net delta of this cycle's strobes, clamped into range.
    always_comb begin
        sum       = $signed({2'b00, count})
                  + $signed({{(W+1){1'b0}}, inc})
                  - $signed({{(W+1){1'b0}}, dec_a})
                  - $signed({{(W+1){1'b0}}, dec_b});
        underflow = sum[W+1];
        count_nxt = clamp_cnt(sum);
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else
            count <= count_nxt;
    end

endmodule

// File: rtl/scoreboard_ctrl.sv
// scoreboard_ctrl: per-register pending-write scoreboard and issue gate
// between decode and execute, with a post-flush drain that holds issue until
// every in-flight write has retired or been squashed.
// Optional: define SCOREBOARD_WB_BYPASS_EN to waive RAW/WAW stalls that a
// same-cycle writeback resolves through register-file forwarding.
module scoreboard_ctrl
    import scoreboard_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = SB_ADDR_W,
    parameter int CNT_W    = 2,
    parameter int TOT_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_rs1,
    input  logic                issue_rs1_used,
    input  logic [ADDR_W-1:0]   issue_rs2,
    input  logic                issue_rs2_used,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic                issue_rd_valid,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_rd,
    input  logic                kill_valid,
    input  logic [ADDR_W-1:0]   kill_rd,
    input  logic                flush,
    output logic                stall,
    output logic                issue_fire,
    output logic [NUM_REGS-1:0] busy,
    output logic                draining,
    output logic                err_underflow
);

    sb_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt [NUM_REGS];
    logic [NUM_REGS-1:0] uf_vec;
    logic [TOT_W-1:0] total;
    logic             total_uf;
    logic             raw1, raw2, waw;
    logic             tot_inc, tot_dec_wb, tot_dec_kill;
    logic [1:0]       dec_cnt;
    logic             drain_done;

    // x0 is never tracked.
    assign cnt[0]    = '0;
    assign uf_vec[0] = 1'b0;
    assign busy[0]   = 1'b0;

    genvar i;
    generate
        for (i = 1; i < NUM_REGS; i++) begin : g_reg
            sb_counter #(.W(CNT_W)) u_cnt (
                .clk       (clk),
                .rst_n     (rst_n),
                .inc       (issue_fire & issue_rd_valid & (issue_rd == ADDR_W'(i))),
                .dec_a     (wb_valid & (wb_rd == ADDR_W'(i))),
                .dec_b     (kill_valid & (kill_rd == ADDR_W'(i))),
                .count     (cnt[i]),
                .underflow (uf_vec[i])
            );
            assign busy[i] = (cnt[i] != '0);
        end
    endgenerate

    assign tot_inc      = issue_fire & issue_rd_valid & (issue_rd != '0);
    assign tot_dec_wb   = wb_valid & (wb_rd != '0);
    assign tot_dec_kill = kill_valid & (kill_rd != '0);

    sb_counter #(.W(TOT_W)) u_total (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (tot_inc),
        .dec_a     (tot_dec_wb),
        .dec_b     (tot_dec_kill),
        .count     (total),
        .underflow (total_uf)
    );

    // Hazard detection and issue gating.
    always_comb begin
        raw1 = issue_rs1_used & (issue_rs1 != '0) & (cnt[issue_rs1] != '0);
        raw2 = issue_rs2_used & (issue_rs2 != '0) & (cnt[issue_rs2] != '0);
        waw  = issue_rd_valid & (issue_rd != '0) & (cnt[issue_rd] == {CNT_W{1'b1}});
`ifdef SCOREBOARD_WB_BYPASS_EN
        if (wb_valid && (wb_rd == issue_rs1) && (cnt[issue_rs1] == CNT_W'(1)))
            raw1 = 1'b0;
        if (wb_valid && (wb_rd == issue_rs2) && (cnt[issue_rs2] == CNT_W'(1)))
            raw2 = 1'b0;
        if (wb_valid && (wb_rd == issue_rd))
            waw = 1'b0;
`endif
        stall      = issue_valid & ((state == SB_DRAIN) | flush | raw1 | raw2 | waw);
        issue_fire = issue_valid & ~stall;
    end

    // No issue fires in DRAIN, so the drain is done once this cycle's
    // retirements cover what is still outstanding.
    assign dec_cnt    = {1'b0, tot_dec_wb} + {1'b0, tot_dec_kill};
    assign drain_done = (total <= TOT_W'(dec_cnt));
    assign draining   = (state == SB_DRAIN);

    // Next-state logic: a flush always (re)enters DRAIN.
    always_comb begin
        state_nxt = state;
        case (state)
            SB_RUN:   if (flush) state_nxt = SB_DRAIN;
            SB_DRAIN: if (!flush && drain_done) state_nxt = SB_RUN;
            default:  state_nxt = SB_RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= SB_RUN;
        else
            state <= state_nxt;
    end

    // Sticky underflow flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_underflow <= 1'b0;
        else if ((|uf_vec) | total_uf)
            err_underflow <= 1'b1;
    end

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Directed bench for scoreboard_ctrl with hand-computed expectations.
module tb_scoreboard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic        issue_rs1_used;
    logic [4:0]  issue_rs2;
    logic        issue_rs2_used;
    logic [4:0]  issue_rd;
    logic        issue_rd_valid;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        kill_valid;
    logic [4:0]  kill_rd;
    logic        flush;
    logic        stall;
    logic        issue_fire;
    logic [31:0] busy;
    logic        draining;
    logic        err_underflow;

    int n_checks = 0;
    int n_pass   = 0;

    scoreboard_ctrl #(
        .NUM_REGS (32),
        .ADDR_W   (5),
        .CNT_W    (2),
        .TOT_W    (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .issue_valid    (issue_valid),
        .issue_rs1      (issue_rs1),
        .issue_rs1_used (issue_rs1_used),
        .issue_rs2      (issue_rs2),
        .issue_rs2_used (issue_rs2_used),
        .issue_rd       (issue_rd),
        .issue_rd_valid (issue_rd_valid),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .kill_valid     (kill_valid),
        .kill_rd        (kill_rd),
        .flush          (flush),
        .stall          (stall),
        .issue_fire     (issue_fire),
        .busy           (busy),
        .draining       (draining),
        .err_underflow  (err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic idle();
        issue_valid    = 1'b0;
        issue_rs1      = '0;
        issue_rs1_used = 1'b0;
        issue_rs2      = '0;
        issue_rs2_used = 1'b0;
        issue_rd       = '0;
        issue_rd_valid = 1'b0;
        wb_valid       = 1'b0;
        wb_rd          = '0;
        kill_valid     = 1'b0;
        kill_rd        = '0;
        flush          = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_wr(input logic [4:0] rd);
        idle();
        issue_valid    = 1'b1;
        issue_rd       = rd;
        issue_rd_valid = 1'b1;
    endtask

    task automatic do_wb(input logic [4:0] rd);
        idle();
        wb_valid = 1'b1;
        wb_rd    = rd;
    endtask

    initial begin
        logic exp_byp_stall;
        idle();
        rst_n = 1'b0;
        #12;
        // reset state
        chk("rst_busy", busy, 32'h0);
        chk("rst_draining", {31'b0, draining}, 32'h0);
        chk("rst_err", {31'b0, err_underflow}, 32'h0);
        issue_valid = 1'b1;
        #1;
        chk("rst_stall", {31'b0, stall}, 32'h0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // RAW on rd=5
        issue_wr(5'd5);
        #1;
        chk("t1_fire_rd5", {31'b0, issue_fire}, 32'h1);
        cyc();
        idle();
        chk("t1_busy5", busy, 32'h20);
        issue_valid = 1'b1; issue_rs1 = 5'd5; issue_rs1_used = 1'b1;
        #1;
        chk("t1_raw_stall", {31'b0, stall}, 32'h1);
        chk("t1_raw_nofire", {31'b0, issue_fire}, 32'h0);
        cyc();
        do_wb(5'd5);
        cyc();
        idle();
        chk("t1_busy_clr", busy, 32'h0);
        issue_valid = 1'b1; issue_rs1 = 5'd5; issue_rs1_used = 1'b1;
        #1;
        chk("t1_fire_after_wb", {31'b0, issue_fire}, 32'h1);
        cyc();

        // x0 is never tracked
        idle();
        issue_valid = 1'b1; issue_rd = 5'd0; issue_rd_valid = 1'b1;
        issue_rs1 = 5'd0; issue_rs1_used = 1'b1;
        #1;
        chk("t2_x0_stall", {31'b0, stall}, 32'h0);
        cyc();
        idle();
        chk("t2_x0_busy", busy, 32'h0);

        // WAW saturation on rd=7
        for (int k = 0; k < 3; k++) begin
            issue_wr(5'd7);
            #1;
            chk("t3_fire_rd7", {31'b0, issue_fire}, 32'h1);
            cyc();
        end
        issue_wr(5'd7);
        #1;
        chk("t3_waw_stall", {31'b0, stall}, 32'h1);
        cyc();
        do_wb(5'd7);
        cyc();
        issue_wr(5'd7);
        #1;
        chk("t3_fire_after_wb", {31'b0, issue_fire}, 32'h1);
        cyc();
        for (int k = 0; k < 2; k++) begin
            do_wb(5'd7);
            cyc();
        end
        idle();
        chk("t3_busy7_still", busy, 32'h80);
        do_wb(5'd7);
        cyc();
        idle();
        chk("t3_busy7_clr", busy, 32'h0);

        // flush and drain
        issue_wr(5'd3);
        cyc();
        issue_wr(5'd4);
        cyc();
        issue_wr(5'd8);
        flush = 1'b1;
        #1;
        chk("t4_flush_stall", {31'b0, stall}, 32'h1);
        chk("t4_flush_nofire", {31'b0, issue_fire}, 32'h0);
        cyc();
        flush = 1'b0;
        #1;
        chk("t4_draining", {31'b0, draining}, 32'h1);
        chk("t4_drain_stall", {31'b0, stall}, 32'h1);
        chk("t4_busy34", busy, 32'h18);
        idle();
        flush = 1'b1;
        cyc();
        idle();
        chk("t4_reflush_drain", {31'b0, draining}, 32'h1);
        kill_valid = 1'b1; kill_rd = 5'd3;
        wb_valid   = 1'b1; wb_rd   = 5'd4;
        cyc();
        idle();
        chk("t4_run_again", {31'b0, draining}, 32'h0);
        chk("t4_busy_clr", busy, 32'h0);

        // flush with nothing outstanding: one DRAIN cycle
        flush = 1'b1;
        cyc();
        idle();
        chk("t4_zero_drain", {31'b0, draining}, 32'h1);
        cyc();
        chk("t4_zero_drain_end", {31'b0, draining}, 32'h0);

        // flush during DRAIN with total 0 keeps DRAIN
        flush = 1'b1;
        cyc();
        cyc();
        chk("t4_flush_holds", {31'b0, draining}, 32'h1);
        idle();
        cyc();
        chk("t4_flush_release", {31'b0, draining}, 32'h0);

        // underflow
        do_wb(5'd9);
        cyc();
        idle();
        chk("t5_uf_busy", busy, 32'h0);
        chk("t5_uf_err", {31'b0, err_underflow}, 32'h1);
        cyc();
        chk("t5_uf_sticky", {31'b0, err_underflow}, 32'h1);

        // async reset in the middle of DRAIN
        issue_wr(5'd10);
        cyc();
        idle();
        flush = 1'b1;
        cyc();
        idle();
        chk("t5_pre_drain", {31'b0, draining}, 32'h1);
        chk("t5_pre_busy10", busy, 32'h400);
        #2;
        rst_n = 1'b0;
        issue_valid = 1'b1;
        #1;
        chk("t5_arst_busy", busy, 32'h0);
        chk("t5_arst_drain", {31'b0, draining}, 32'h0);
        chk("t5_arst_err", {31'b0, err_underflow}, 32'h0);
        chk("t5_arst_stall", {31'b0, stall}, 32'h0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // same-cycle writeback of a pending source
        issue_wr(5'd6);
        cyc();
        idle();
        issue_valid = 1'b1; issue_rs2 = 5'd6; issue_rs2_used = 1'b1;
        wb_valid = 1'b1; wb_rd = 5'd6;
`ifdef SCOREBOARD_WB_BYPASS_EN
        exp_byp_stall = 1'b0;
`else
        exp_byp_stall = 1'b1;
`endif
        #1;
        chk("t6_byp_stall", {31'b0, stall}, {31'b0, exp_byp_stall});
        chk("t6_byp_fire", {31'b0, issue_fire}, {31'b0, ~exp_byp_stall});
        cyc();
        idle();
        chk("t6_busy_clr", busy, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
